// File: rtl/scan_mux.sv
// Registered N-channel, W-bit multiplexer with manual select and an auto-scan
// mode that dwells DWELL cycles per channel; ch_stb pulses on every channel change.
module scan_mux #(
  parameter int N     = 4,
  parameter int W     = 8,
  parameter int DWELL = 100_000_000,
  localparam int CW   = $clog2(N)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N*W-1:0] i,
  input  logic [CW-1:0]  s,
  input  logic           mode,
  input  logic           hold,
  output logic [W-1:0]   o,
  output logic [CW-1:0]  ch,
  output logic           ch_stb
);

  localparam int DW = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam int NP = 1 << CW;
  localparam logic [DW-1:0] CNT_LAST = DW'(DWELL - 1);
  localparam logic [CW-1:0] CH_LAST  = CW'(N - 1);

  logic [DW-1:0] cnt_reg, cnt_next;
  logic          mode_q_reg;
  logic [CW-1:0] ch_next;
  logic          s_ok;
  logic [W-1:0]  chan [NP];

  // Pad the channel table to a power of two so any index is in range.
  generate
    for (genvar gi = 0; gi < NP; gi++) begin : g_chan
      if (gi < N) begin : g_live
        assign chan[gi] = i[gi*W +: W];
      end else begin : g_pad
        assign chan[gi] = '0;
      end
    end
  endgenerate

  generate
    if (NP == N) begin : g_s_full
      assign s_ok = 1'b1;
    end else begin : g_s_part
      assign s_ok = (s <= CH_LAST);
    end
  endgenerate

  always_comb begin
    ch_next  = ch;
    cnt_next = cnt_reg;
    if (!mode) begin
      cnt_next = '0;
      if (s_ok) ch_next = s;
    end else if (mode != mode_q_reg) begin
      // Entering auto: keep the current channel and start a fresh dwell.
      cnt_next = '0;
    end else if (!hold) begin
      if (cnt_reg == CNT_LAST) begin
        cnt_next = '0;
        ch_next  = (ch == CH_LAST) ? '0 : ch + CW'(1);
      end else begin
        cnt_next = cnt_reg + DW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      o          <= '0;
      ch         <= '0;
      ch_stb     <= 1'b0;
      cnt_reg    <= '0;
      mode_q_reg <= 1'b0;
    end else begin
      o          <= chan[ch_next];
      ch         <= ch_next;
      ch_stb     <= (ch_next != ch);
      cnt_reg    <= cnt_next;
      mode_q_reg <= mode;
    end
  end

endmodule

// File: tb/tb_scan_mux.sv
// Directed bench for scan_mux: a 4-channel DWELL=3 instance, a 3-channel
// instance for illegal selects, and a DWELL=1 instance for continuous scanning.
module tb_scan_mux;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, mode, hold;
  logic [1:0]  s, s3;
  logic [31:0] i;
  logic [7:0]  o4, o3, o1;
  logic [1:0]  ch4, ch3, ch1;
  logic        stb4, stb3, stb1;

  scan_mux #(.N(4), .W(8), .DWELL(3)) dut4 (
    .clk(clk), .rst(rst), .i(i), .s(s), .mode(mode), .hold(hold),
    .o(o4), .ch(ch4), .ch_stb(stb4));

  scan_mux #(.N(3), .W(8), .DWELL(3)) dut3 (
    .clk(clk), .rst(rst), .i(i[23:0]), .s(s3), .mode(1'b0), .hold(1'b0),
    .o(o3), .ch(ch3), .ch_stb(stb3));

  scan_mux #(.N(4), .W(8), .DWELL(1)) dut1 (
    .clk(clk), .rst(rst), .i(i), .s(s), .mode(mode), .hold(hold),
    .o(o1), .ch(ch1), .ch_stb(stb1));

  typedef struct {
    logic       rst;
    logic       mode;
    logic       hold;
    logic [1:0] s;
    logic [7:0] o;
    logic [1:0] ch;
    logic       stb;
  } vec_t;

  int checks = 0;
  int fails  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic step(input logic r, input logic m, input logic h, input logic [1:0] sv);
    rst = r; mode = m; hold = h; s = sv;
    @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input string tag, input logic [7:0] ao, input logic [1:0] ach,
                            input logic astb, input logic [7:0] eo, input logic [1:0] ech,
                            input logic estb);
    $display("%s: o=%02h ch=%0d stb=%0d (exp o=%02h ch=%0d stb=%0d)",
             tag, ao, ach, astb, eo, ech, estb);
    check({tag, ".o"}, 32'(ao), 32'(eo));
    check({tag, ".ch"}, 32'(ach), 32'(ech));
    check({tag, ".stb"}, 32'(astb), 32'(estb));
  endtask

  task automatic run4(input string tag, input logic r, input logic m, input logic h,
                      input logic [1:0] sv, input logic [7:0] eo, input logic [1:0] ech,
                      input logic estb);
    step(r, m, h, sv);
    expect_out(tag, o4, ch4, stb4, eo, ech, estb);
  endtask

  vec_t vecs [20];

  initial begin
    // Reset, manual select, then auto scan with wrap (DWELL=3).
    vecs[0]  = '{1'b1, 1'b0, 1'b0, 2'd0, 8'h00, 2'd0, 1'b0};
    vecs[1]  = '{1'b1, 1'b0, 1'b0, 2'd2, 8'h00, 2'd0, 1'b0};
    vecs[2]  = '{1'b0, 1'b0, 1'b0, 2'd2, 8'h33, 2'd2, 1'b1};
    vecs[3]  = '{1'b0, 1'b0, 1'b0, 2'd2, 8'h33, 2'd2, 1'b0};
    vecs[4]  = '{1'b0, 1'b0, 1'b0, 2'd1, 8'h22, 2'd1, 1'b1};
    vecs[5]  = '{1'b0, 1'b0, 1'b0, 2'd0, 8'h11, 2'd0, 1'b1};
    vecs[6]  = '{1'b0, 1'b0, 1'b0, 2'd0, 8'h11, 2'd0, 1'b0};
    vecs[7]  = '{1'b0, 1'b1, 1'b0, 2'd0, 8'h11, 2'd0, 1'b0};
    vecs[8]  = '{1'b0, 1'b1, 1'b0, 2'd0, 8'h11, 2'd0, 1'b0};
    vecs[9]  = '{1'b0, 1'b1, 1'b0, 2'd0, 8'h11, 2'd0, 1'b0};
    vecs[10] = '{1'b0, 1'b1, 1'b0, 2'd0, 8'h22, 2'd1, 1'b1};
    vecs[11] = '{1'b0, 1'b1, 1'b0, 2'd0, 8'h22, 2'd1, 1'b0};
    vecs[12] = '{1'b0, 1'b1, 1'b0, 2'd0, 8'h22, 2'd1, 1'b0};
    vecs[13] = '{1'b0, 1'b1, 1'b0, 2'd0, 8'h33, 2'd2, 1'b1};
    vecs[14] = '{1'b0, 1'b1, 1'b0, 2'd0, 8'h33, 2'd2, 1'b0};
    vecs[15] = '{1'b0, 1'b1, 1'b0, 2'd0, 8'h33, 2'd2, 1'b0};
    vecs[16] = '{1'b0, 1'b1, 1'b0, 2'd0, 8'h44, 2'd3, 1'b1};
    vecs[17] = '{1'b0, 1'b1, 1'b0, 2'd0, 8'h44, 2'd3, 1'b0};
    vecs[18] = '{1'b0, 1'b1, 1'b0, 2'd0, 8'h44, 2'd3, 1'b0};
    vecs[19] = '{1'b0, 1'b1, 1'b0, 2'd0, 8'h11, 2'd0, 1'b1};

    i = 32'h44332211; s3 = 2'd0;
    rst = 1'b1; mode = 1'b0; hold = 1'b0; s = 2'd0;
    @(negedge clk);

    for (int k = 0; k < 20; k++) begin
      step(vecs[k].rst, vecs[k].mode, vecs[k].hold, vecs[k].s);
      expect_out($sformatf("vec%0d", k), o4, ch4, stb4, vecs[k].o, vecs[k].ch, vecs[k].stb);
    end

    // Hold at cnt=2 on channel 1; data keeps flowing while frozen.
    run4("h_a", 1'b0, 1'b1, 1'b0, 2'd0, 8'h11, 2'd0, 1'b0);
    run4("h_b", 1'b0, 1'b1, 1'b0, 2'd0, 8'h11, 2'd0, 1'b0);
    run4("h_c", 1'b0, 1'b1, 1'b0, 2'd0, 8'h22, 2'd1, 1'b1);
    run4("h_d", 1'b0, 1'b1, 1'b0, 2'd0, 8'h22, 2'd1, 1'b0);
    run4("h_e", 1'b0, 1'b1, 1'b0, 2'd0, 8'h22, 2'd1, 1'b0);
    run4("hold1", 1'b0, 1'b1, 1'b1, 2'd0, 8'h22, 2'd1, 1'b0);
    run4("hold2", 1'b0, 1'b1, 1'b1, 2'd0, 8'h22, 2'd1, 1'b0);
    i[15:8] = 8'h5A;
    run4("hold3", 1'b0, 1'b1, 1'b1, 2'd0, 8'h5A, 2'd1, 1'b0);
    run4("hold4", 1'b0, 1'b1, 1'b1, 2'd0, 8'h5A, 2'd1, 1'b0);
    run4("hold5", 1'b0, 1'b1, 1'b1, 2'd0, 8'h5A, 2'd1, 1'b0);
    run4("unhold", 1'b0, 1'b1, 1'b0, 2'd0, 8'h33, 2'd2, 1'b1);
    i[15:8] = 8'h22;

    // Auto -> manual at ch=2/cnt=1, then back to auto with a full dwell on ch 0.
    run4("m_a", 1'b0, 1'b1, 1'b0, 2'd0, 8'h33, 2'd2, 1'b0);
    run4("to_man", 1'b0, 1'b0, 1'b0, 2'd0, 8'h11, 2'd0, 1'b1);
    run4("to_auto0", 1'b0, 1'b1, 1'b0, 2'd0, 8'h11, 2'd0, 1'b0);
    run4("to_auto1", 1'b0, 1'b1, 1'b0, 2'd0, 8'h11, 2'd0, 1'b0);
    run4("to_auto2", 1'b0, 1'b1, 1'b0, 2'd0, 8'h11, 2'd0, 1'b0);
    run4("to_auto3", 1'b0, 1'b1, 1'b0, 2'd0, 8'h22, 2'd1, 1'b1);

    // Advance to ch=3, then reset mid-scan and restart from channel 0.
    run4("r_a", 1'b0, 1'b1, 1'b0, 2'd0, 8'h22, 2'd1, 1'b0);
    run4("r_b", 1'b0, 1'b1, 1'b0, 2'd0, 8'h22, 2'd1, 1'b0);
    run4("r_c", 1'b0, 1'b1, 1'b0, 2'd0, 8'h33, 2'd2, 1'b1);
    run4("r_d", 1'b0, 1'b1, 1'b0, 2'd0, 8'h33, 2'd2, 1'b0);
    run4("r_e", 1'b0, 1'b1, 1'b0, 2'd0, 8'h33, 2'd2, 1'b0);
    run4("r_f", 1'b0, 1'b1, 1'b0, 2'd0, 8'h44, 2'd3, 1'b1);
    run4("midrst", 1'b1, 1'b1, 1'b0, 2'd0, 8'h00, 2'd0, 1'b0);
    run4("rs0", 1'b0, 1'b1, 1'b0, 2'd0, 8'h11, 2'd0, 1'b0);
    run4("rs1", 1'b0, 1'b1, 1'b0, 2'd0, 8'h11, 2'd0, 1'b0);
    run4("rs2", 1'b0, 1'b1, 1'b0, 2'd0, 8'h11, 2'd0, 1'b0);
    run4("rs3", 1'b0, 1'b1, 1'b0, 2'd0, 8'h22, 2'd1, 1'b1);

    // N=3 instance: index 3 is illegal and must be ignored.
    s3 = 2'd1; step(1'b0, 1'b1, 1'b0, 2'd0);
    expect_out("n3_sel1", o3, ch3, stb3, 8'h22, 2'd1, 1'b1);
    s3 = 2'd3; step(1'b0, 1'b1, 1'b0, 2'd0);
    expect_out("n3_ill_a", o3, ch3, stb3, 8'h22, 2'd1, 1'b0);
    step(1'b0, 1'b1, 1'b0, 2'd0);
    expect_out("n3_ill_b", o3, ch3, stb3, 8'h22, 2'd1, 1'b0);
    s3 = 2'd2; step(1'b0, 1'b1, 1'b0, 2'd0);
    expect_out("n3_sel2", o3, ch3, stb3, 8'h33, 2'd2, 1'b1);

    // DWELL=1 instance: advances every cycle, strobe stays high.
    step(1'b1, 1'b1, 1'b0, 2'd0);
    expect_out("d1_rst", o1, ch1, stb1, 8'h00, 2'd0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 2'd0);
    expect_out("d1_0", o1, ch1, stb1, 8'h11, 2'd0, 1'b0);
    for (int k = 1; k <= 5; k++) begin
      logic [1:0] ech;
      ech = 2'(k);
      step(1'b0, 1'b1, 1'b0, 2'd0);
      expect_out($sformatf("d1_%0d", k), o1, ch1, stb1, i[8*ech +: 8], ech, 1'b1);
    end
    step(1'b0, 1'b1, 1'b1, 2'd0);
    expect_out("d1_hold", o1, ch1, stb1, 8'h22, 2'd1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
